// File: rtl/bsg_axil_fifo_master_pkg.sv
// Shared constants and request bundle for the bsg ready/valid to
// AXI-Lite single-outstanding master.
package bsg_axil_fifo_master_pkg;

  localparam logic [2:0] e_idle  = 3'd0;
  localparam logic [2:0] e_write = 3'd1;
  localparam logic [2:0] e_wresp = 3'd2;
  localparam logic [2:0] e_read  = 3'd3;
  localparam logic [2:0] e_rdata = 3'd4;
  localparam logic [2:0] e_resp  = 3'd5;

  localparam logic [1:0] axil_resp_okay   = 2'b00;
  localparam logic [1:0] axil_resp_slverr = 2'b10;
  localparam logic [1:0] axil_resp_decerr = 2'b11;

endpackage

`define BSG_AXIL_FIFO_MASTER_REQ_S(aw, dw) \
  typedef struct packed { \
    logic              we; \
    logic [(aw)-1:0]   addr; \
    logic [(dw)-1:0]   data; \
    logic [(dw)/8-1:0] wstrb; \
  } bsg_axil_req_s;

// File: rtl/bsg_axil_fifo_master.sv
// Ready/valid request stream to single AXI-Lite master transactions,
// one outstanding at a time, one response per request.
module bsg_axil_fifo_master
  import bsg_axil_fifo_master_pkg::*;
#(
  parameter int         addr_width_p = 32,
  parameter int         data_width_p = 32,
  parameter logic [2:0] prot_p       = 3'b000
) (
  input  logic                      clk_i,
  input  logic                      reset_i,

  input  logic                      req_v_i,
  output logic                      req_ready_and_o,
  input  logic                      req_we_i,
  input  logic [addr_width_p-1:0]   req_addr_i,
  input  logic [data_width_p-1:0]   req_data_i,
  input  logic [data_width_p/8-1:0] req_wstrb_i,

  output logic                      resp_v_o,
  input  logic                      resp_ready_and_i,
  output logic                      resp_we_o,
  output logic [data_width_p-1:0]   resp_data_o,
  output logic                      resp_err_o,

  output logic [addr_width_p-1:0]   m_axil_awaddr_o,
  output logic [2:0]                m_axil_awprot_o,
  output logic                      m_axil_awvalid_o,
  input  logic                      m_axil_awready_i,

  output logic [data_width_p-1:0]   m_axil_wdata_o,
  output logic [data_width_p/8-1:0] m_axil_wstrb_o,
  output logic                      m_axil_wvalid_o,
  input  logic                      m_axil_wready_i,

  input  logic [1:0]                m_axil_bresp_i,
  input  logic                      m_axil_bvalid_i,
  output logic                      m_axil_bready_o,

  output logic [addr_width_p-1:0]   m_axil_araddr_o,
  output logic [2:0]                m_axil_arprot_o,
  output logic                      m_axil_arvalid_o,
  input  logic                      m_axil_arready_i,

  input  logic [data_width_p-1:0]   m_axil_rdata_i,
  input  logic [1:0]                m_axil_rresp_i,
  input  logic                      m_axil_rvalid_i,
  output logic                      m_axil_rready_o
);

  if (!(data_width_p == 32 || data_width_p == 64)) begin : g_bad_width
    $error("bsg_axil_fifo_master: data_width_p must be 32 or 64");
  end

  `BSG_AXIL_FIFO_MASTER_REQ_S(addr_width_p, data_width_p)

  logic [2:0]              r_state;
  bsg_axil_req_s           r_req;
  logic                    r_aw_done;
  logic                    r_w_done;
  logic                    r_resp_we;
  logic                    r_resp_err;
  logic [data_width_p-1:0] r_resp_data;

  logic w_aw_fire;
  logic w_w_fire;
  logic w_aw_all;
  logic w_w_all;

  // Every ready/valid is a pure function of state: no path from req_* inputs.
  assign req_ready_and_o  = (r_state == e_idle);
  assign m_axil_awvalid_o = (r_state == e_write) & ~r_aw_done;
  assign m_axil_wvalid_o  = (r_state == e_write) & ~r_w_done;
  assign m_axil_bready_o  = (r_state == e_wresp);
  assign m_axil_arvalid_o = (r_state == e_read);
  assign m_axil_rready_o  = (r_state == e_rdata);
  assign resp_v_o         = (r_state == e_resp);

  assign m_axil_awaddr_o = r_req.addr;
  assign m_axil_awprot_o = prot_p;
  assign m_axil_wdata_o  = r_req.data;
  assign m_axil_wstrb_o  = r_req.wstrb;
  assign m_axil_araddr_o = r_req.addr;
  assign m_axil_arprot_o = prot_p;

  assign resp_we_o   = r_resp_we;
  assign resp_data_o = r_resp_data;
  assign resp_err_o  = r_resp_err;

  assign w_aw_fire = m_axil_awvalid_o & m_axil_awready_i;
  assign w_w_fire  = m_axil_wvalid_o & m_axil_wready_i;
  assign w_aw_all  = r_aw_done | w_aw_fire;
  assign w_w_all   = r_w_done | w_w_fire;

  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      r_state     <= e_idle;
      r_aw_done   <= 1'b0;
      r_w_done    <= 1'b0;
      r_resp_we   <= 1'b0;
      r_resp_err  <= 1'b0;
      r_resp_data <= '0;
    end else begin
      unique case (r_state)
        e_idle: begin
          if (req_v_i) begin
            r_req.we    <= req_we_i;
            r_req.addr  <= req_addr_i;
            r_req.data  <= req_data_i;
            r_req.wstrb <= req_wstrb_i;
            r_aw_done   <= 1'b0;
            r_w_done    <= 1'b0;
            r_state     <= req_we_i ? e_write : e_read;
          end
        end
        e_write: begin
          if (w_aw_fire) r_aw_done <= 1'b1;
          if (w_w_fire)  r_w_done  <= 1'b1;
          if (w_aw_all & w_w_all) r_state <= e_wresp;
        end
        e_wresp: begin
          if (m_axil_bvalid_i) begin
            r_resp_we   <= r_req.we;
            r_resp_data <= '0;
            r_resp_err  <= (m_axil_bresp_i != axil_resp_okay);
            r_state     <= e_resp;
          end
        end
        e_read: begin
          if (m_axil_arready_i) r_state <= e_rdata;
        end
        e_rdata: begin
          if (m_axil_rvalid_i) begin
            r_resp_we   <= r_req.we;
            r_resp_data <= m_axil_rdata_i;
            r_resp_err  <= (m_axil_rresp_i != axil_resp_okay);
            r_state     <= e_resp;
          end
        end
        e_resp: begin
          if (resp_ready_and_i) r_state <= e_idle;
        end
        default: r_state <= e_idle;
      endcase
    end
  end

endmodule

// File: tb/tb_bsg_axil_fifo_master.sv
// Bench for bsg_axil_fifo_master: scripted AXI-Lite slave plus a
// response scoreboard.
module tb_bsg_axil_fifo_master;

  logic        clk = 1'b0;
  logic        reset;
  logic        req_v, req_ready, req_we;
  logic [31:0] req_addr, req_data;
  logic [3:0]  req_wstrb;
  logic        resp_v, resp_ready, resp_we, resp_err;
  logic [31:0] resp_data;
  logic [31:0] awaddr, wdata, araddr, rdata;
  logic [2:0]  awprot, arprot;
  logic [3:0]  wstrb;
  logic        awvalid, awready, wvalid, wready;
  logic        bvalid, bready, arvalid, arready, rvalid, rready;
  logic [1:0]  bresp, rresp;

  always #5 clk = ~clk;

  bsg_axil_fifo_master dut (
    .clk_i(clk), .reset_i(reset),
    .req_v_i(req_v), .req_ready_and_o(req_ready), .req_we_i(req_we),
    .req_addr_i(req_addr), .req_data_i(req_data), .req_wstrb_i(req_wstrb),
    .resp_v_o(resp_v), .resp_ready_and_i(resp_ready), .resp_we_o(resp_we),
    .resp_data_o(resp_data), .resp_err_o(resp_err),
    .m_axil_awaddr_o(awaddr), .m_axil_awprot_o(awprot),
    .m_axil_awvalid_o(awvalid), .m_axil_awready_i(awready),
    .m_axil_wdata_o(wdata), .m_axil_wstrb_o(wstrb),
    .m_axil_wvalid_o(wvalid), .m_axil_wready_i(wready),
    .m_axil_bresp_i(bresp), .m_axil_bvalid_i(bvalid), .m_axil_bready_o(bready),
    .m_axil_araddr_o(araddr), .m_axil_arprot_o(arprot),
    .m_axil_arvalid_o(arvalid), .m_axil_arready_i(arready),
    .m_axil_rdata_i(rdata), .m_axil_rresp_i(rresp),
    .m_axil_rvalid_i(rvalid), .m_axil_rready_o(rready)
  );

  int n_checks = 0;
  int n_errors = 0;

  task automatic check(input string tag, input logic [63:0] act,
                       input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h", tag, act, exp);
    end
  endtask

  typedef struct {
    logic        we;
    logic [31:0] data;
    logic        err;
  } exp_t;
  exp_t sb[$];

  int          cfg_aw_lat = 0, cfg_w_lat = 0, cfg_b_lat = 0;
  int          cfg_ar_lat = 0, cfg_r_lat = 0, cfg_hold = 0;
  logic [1:0]  cfg_bresp = 2'b00, cfg_rresp = 2'b00;
  logic [31:0] cfg_rdata = '0;
  logic [31:0] exp_addr = '0, exp_data = '0;
  logic [3:0]  exp_strb = '0;
  int          aw_hs = 0, w_hs = 0, b_hs = 0, ar_hs = 0, r_hs = 0, n_resp = 0;

  // Scripted slave: outputs change on negedge, handshakes land on posedge.
  bit aw_fire, w_fire, b_fire, ar_fire, r_fire;
  bit aw_seen, w_seen, ar_seen;
  int aw_wait, w_wait, b_wait, ar_wait, r_wait;
  initial begin
    awready = 0; wready = 0; arready = 0;
    bvalid = 0; bresp = 0; rvalid = 0; rresp = 0; rdata = 0;
    forever begin
      @(negedge clk);
      if (reset) begin
        awready = 0; wready = 0; arready = 0; bvalid = 0; rvalid = 0;
        {aw_fire, w_fire, b_fire, ar_fire, r_fire} = '0;
        {aw_seen, w_seen, ar_seen} = '0;
        aw_wait = 0; w_wait = 0; b_wait = 0; ar_wait = 0; r_wait = 0;
      end else begin
        if (aw_fire) begin aw_fire = 0; aw_seen = 1; end
        if (w_fire)  begin w_fire = 0;  w_seen = 1;  end
        if (ar_fire) begin ar_fire = 0; ar_seen = 1; end
        if (b_fire) begin
          b_fire = 0; bvalid = 0; aw_seen = 0; w_seen = 0; b_wait = 0;
        end
        if (r_fire) begin
          r_fire = 0; rvalid = 0; ar_seen = 0; r_wait = 0;
        end
        awready = 0; wready = 0; arready = 0;
        if (aw_seen) check("aw_drop", awvalid, 0);
        else if (awvalid) begin
          if (aw_wait >= cfg_aw_lat) begin
            awready = 1; aw_fire = 1; aw_hs++; aw_wait = 0;
            check("awaddr", awaddr, exp_addr);
            check("awprot", awprot, 0);
          end else aw_wait++;
        end
        if (w_seen) check("w_drop", wvalid, 0);
        else if (wvalid) begin
          if (w_wait >= cfg_w_lat) begin
            wready = 1; w_fire = 1; w_hs++; w_wait = 0;
            check("wdata", wdata, exp_data);
            check("wstrb", wstrb, exp_strb);
          end else w_wait++;
        end
        if (awvalid | wvalid) check("bready_early", bready, 0);
        if (aw_seen && w_seen && !bvalid) begin
          if (b_wait >= cfg_b_lat) begin bvalid = 1; bresp = cfg_bresp; end
          else b_wait++;
        end
        if (bvalid && bready) begin b_fire = 1; b_hs++; end
        if (ar_seen) check("ar_drop", arvalid, 0);
        else if (arvalid) begin
          check("rready_early", rready, 0);
          if (ar_wait >= cfg_ar_lat) begin
            arready = 1; ar_fire = 1; ar_hs++; ar_wait = 0;
            check("araddr", araddr, exp_addr);
            check("arprot", arprot, 0);
          end else ar_wait++;
        end
        if (ar_seen && !rvalid) begin
          if (r_wait >= cfg_r_lat) begin
            rvalid = 1; rdata = cfg_rdata; rresp = cfg_rresp;
          end else r_wait++;
        end
        if (rvalid && rready) begin r_fire = 1; r_hs++; end
        if (awvalid | wvalid | bready | arvalid | rready | resp_v)
          check("req_rdy_busy", req_ready, 0);
      end
    end
  end

  // Response sink with optional backpressure and scoreboard pop.
  bit          resp_fire;
  int          hold_cnt;
  logic [33:0] snap;
  initial begin
    exp_t e;
    resp_ready = 0; resp_fire = 0; hold_cnt = 0; snap = '0;
    forever begin
      @(negedge clk);
      if (reset) begin
        resp_ready = 0; resp_fire = 0; hold_cnt = 0;
      end else begin
        if (resp_fire) begin resp_fire = 0; resp_ready = 0; end
        if (resp_v) begin
          if (hold_cnt == 0) snap = {resp_we, resp_err, resp_data};
          else check("resp_stable", {resp_we, resp_err, resp_data}, snap);
          if (hold_cnt < cfg_hold) begin
            resp_ready = 0; hold_cnt++;
            check("bp_axi_idle", {awvalid, wvalid, arvalid, bready, rready}, 0);
          end else begin
            resp_ready = 1; resp_fire = 1; hold_cnt = 0; n_resp++;
            if (sb.size() == 0) check("sb_empty", 1, 0);
            else begin
              e = sb.pop_front();
              check("resp_we", resp_we, e.we);
              check("resp_data", resp_data, e.data);
              check("resp_err", resp_err, e.err);
            end
          end
        end
      end
    end
  end

  task automatic send(input logic we, input logic [31:0] addr,
                      input logic [31:0] data, input logic [3:0] strb,
                      input logic [31:0] edata, input logic eerr,
                      input bit wait_done);
    int   k;
    int   target;
    exp_t e;
    k = 0;
    target = n_resp + 1;
    @(negedge clk);
    exp_addr = addr; exp_data = data; exp_strb = strb;
    req_v = 1; req_we = we; req_addr = addr; req_data = data; req_wstrb = strb;
    while (!req_ready && k < 50) begin @(negedge clk); k++; end
    if (k >= 50) begin
      check("req_timeout", 0, 1);
      req_v = 0;
      return;
    end
    e.we = we; e.data = edata; e.err = eerr;
    sb.push_back(e);
    @(posedge clk);
    #1 req_v = 0;
    if (wait_done) begin
      k = 0;
      while (n_resp < target && k < 200) begin @(negedge clk); k++; end
      if (k >= 200) check("resp_timeout", 0, 1);
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    int b0, k;
    reset = 1; req_v = 0; req_we = 0;
    req_addr = 0; req_data = 0; req_wstrb = 0;
    repeat (3) @(posedge clk);
    #1;
    check("rst_valids", {awvalid, wvalid, arvalid, bready, rready, resp_v}, 0);
    check("rst_err", resp_err, 0);
    check("rst_data", resp_data, 0);
    check("rst_ready", req_ready, 1);
    @(negedge clk) reset = 0;

    // single write, same-cycle aw/w
    b0 = b_hs;
    send(1, 32'h1000_0010, 32'hDEAD_BEEF, 4'hF, 32'h0, 0, 1);
    check("wr1_bhs", b_hs - b0, 1);

    // split write handshake
    b0 = b_hs; cfg_w_lat = 3;
    send(1, 32'h1000_0020, 32'h0BAD_F00D, 4'h5, 32'h0, 0, 1);
    check("wr2_bhs", b_hs - b0, 1);
    cfg_w_lat = 0;

    // read with 4-cycle data latency
    cfg_r_lat = 4; cfg_rdata = 32'h1234_5678;
    send(0, 32'h1000_0004, 32'hFFFF_FFFF, 4'hF, 32'h1234_5678, 0, 1);
    cfg_r_lat = 0;

    // error responses
    cfg_bresp = 2'b10; cfg_b_lat = 2;
    send(1, 32'h2000_0000, 32'h5555_AAAA, 4'h3, 32'h0, 1, 1);
    cfg_bresp = 2'b00; cfg_b_lat = 0;
    cfg_rresp = 2'b11; cfg_rdata = 32'hCAFE_F00D; cfg_ar_lat = 2;
    send(0, 32'h2000_0008, 32'h0, 4'h0, 32'hCAFE_F00D, 1, 1);
    cfg_rresp = 2'b00; cfg_ar_lat = 0;

    // response backpressure
    cfg_hold = 10; cfg_rdata = 32'hA5A5_5A5A;
    send(0, 32'h3000_0000, 32'h0, 4'h0, 32'hA5A5_5A5A, 0, 1);
    cfg_hold = 10;
    send(1, 32'h3000_0004, 32'h8765_4321, 4'hC, 32'h0, 0, 1);
    cfg_hold = 0;

    // reset while waiting for read data
    cfg_r_lat = 1000; b0 = ar_hs;
    send(0, 32'h4000_0000, 32'h0, 4'h0, 32'h0, 0, 0);
    k = 0;
    while (ar_hs == b0 && k < 50) begin @(negedge clk); k++; end
    check("mid_ar_seen", ar_hs - b0, 1);
    repeat (2) @(negedge clk);
    check("mid_rready", rready, 1);
    reset = 1;
    @(posedge clk);
    #1;
    check("mid_valids", {awvalid, wvalid, arvalid, bready, rready, resp_v}, 0);
    check("mid_ready", req_ready, 1);
    sb.delete();
    @(negedge clk) reset = 0;
    cfg_r_lat = 1; cfg_rdata = 32'h0BAD_C0DE;
    send(0, 32'h0, 32'h0, 4'h0, 32'h0BAD_C0DE, 0, 1);

    repeat (3) @(negedge clk);
    check("sb_drained", sb.size(), 0);
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
